// File: rtl/prog_loader.sv
// Byte-stream loader: length-prefixed image -> little-endian words into instruction memory,
// holding the core in reset until complete. Optional trailing checksum: PROG_LOADER_CHECKSUM_EN.
module prog_loader #(
  parameter int unsigned ADDR_W    = 10,
  parameter int unsigned MAX_WORDS = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [31:0]       imem_wdata,
  output logic              core_rst,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    HDR0  = 3'd0,
    HDR1  = 3'd1,
    DATA  = 3'd2,
    WRITE = 3'd3,
    DONE  = 3'd4,
    ERR   = 3'd5
`ifdef PROG_LOADER_CHECKSUM_EN
    ,
    CHK   = 3'd6
`endif
  } state_t;

  state_t           state, state_n;
  logic [CNT_W-1:0] n_words, n_words_n;
  logic [CNT_W-1:0] idx, idx_n;
  logic [1:0]       cnt, cnt_n;
  logic [31:0]      wbuf, wbuf_n;
  logic [CNT_W-1:0] hdr;
  logic             xfer;
`ifdef PROG_LOADER_CHECKSUM_EN
  logic [7:0]       sum, sum_n;
  logic [7:0]       chk;
`endif

  // State and datapath registers; outputs are registered from the next state
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= HDR0;
      n_words    <= '0;
      idx        <= '0;
      cnt        <= '0;
      wbuf       <= '0;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum        <= '0;
`endif
      rx_ready   <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
      core_rst   <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
    end else begin
      state    <= state_n;
      n_words  <= n_words_n;
      idx      <= idx_n;
      cnt      <= cnt_n;
      wbuf     <= wbuf_n;
`ifdef PROG_LOADER_CHECKSUM_EN
      sum      <= sum_n;
      rx_ready <= (state_n == HDR0) || (state_n == HDR1) || (state_n == DATA) || (state_n == CHK);
`else
      rx_ready <= (state_n == HDR0) || (state_n == HDR1) || (state_n == DATA);
`endif
      imem_we  <= (state_n == WRITE);
      core_rst <= (state_n != DONE);
      busy     <= (state_n != HDR0) && (state_n != DONE) && (state_n != ERR);
      done     <= (state_n == DONE);
      err      <= (state_n == ERR);
      // Address/data hold their last value between strobes
      if (state_n == WRITE) begin
        imem_addr  <= ADDR_W'(idx_n);
        imem_wdata <= wbuf_n;
      end
    end
  end

  // Next-state and datapath update
  always_comb begin
    state_n   = state;
    n_words_n = n_words;
    idx_n     = idx;
    cnt_n     = cnt;
    wbuf_n    = wbuf;
    hdr       = {rx_data, n_words[7:0]};
    xfer      = rx_valid && rx_ready;
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_n     = sum;
    chk       = sum + rx_data;
`endif
    case (state)
      HDR0: begin
        if (xfer) begin
          n_words_n[7:0] = rx_data;
          state_n        = HDR1;
        end
      end
      HDR1: begin
        if (xfer) begin
          n_words_n[15:8] = rx_data;
          if ((hdr == '0) || (32'(hdr) > MAX_WORDS)) begin
            state_n = ERR;
          end else begin
            state_n = DATA;
            idx_n   = '0;
            cnt_n   = '0;
`ifdef PROG_LOADER_CHECKSUM_EN
            sum_n   = '0;
`endif
          end
        end
      end
      DATA: begin
        if (xfer) begin
          wbuf_n[{cnt, 3'b000} +: 8] = rx_data;
`ifdef PROG_LOADER_CHECKSUM_EN
          sum_n = chk;
`endif
          cnt_n = cnt + 2'd1;
          if (cnt == 2'd3) begin
            state_n = WRITE;
          end
        end
      end
      WRITE: begin
        if (idx == n_words - 16'd1) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          state_n = CHK;
`else
          state_n = DONE;
`endif
        end else begin
          idx_n   = idx + 16'd1;
          state_n = DATA;
        end
      end
`ifdef PROG_LOADER_CHECKSUM_EN
      CHK: begin
        if (xfer) begin
          state_n = (chk == 8'h00) ? DONE : ERR;
        end
      end
`endif
      DONE: state_n = DONE;
      ERR:  state_n = ERR;
      default: state_n = HDR0;
    endcase
  end

endmodule

// File: tb/tb_prog_loader.sv
// Directed bench for prog_loader: cycle-by-cycle vector table plus a full-size image sequence.
module tb_prog_loader;

  localparam int unsigned ADDR_W    = 10;
  localparam int unsigned MAX_WORDS = 1024;

  logic              clk;
  logic              rst;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              core_rst;
  logic              busy;
  logic              done;
  logic              err;

  prog_loader #(.ADDR_W(ADDR_W), .MAX_WORDS(MAX_WORDS)) dut (
    .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .core_rst(core_rst), .busy(busy), .done(done), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              rdy;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic              crst;
    logic              busy;
    logic              done;
    logic              err;
  } out_t;

  typedef struct {
    string      name;
    logic       rst;
    logic       valid;
    logic [7:0] data;
    out_t       exp;
  } vec_t;

  vec_t q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  function automatic out_t o(input logic rdy, input logic we, input logic [ADDR_W-1:0] a,
                             input logic [31:0] w, input logic cr, input logic b,
                             input logic dn, input logic er);
    out_t r;
    r.rdy = rdy; r.we = we; r.addr = a; r.wdata = w;
    r.crst = cr; r.busy = b; r.done = dn; r.err = er;
    return r;
  endfunction

  function automatic out_t o_rst();                                      return o(1, 0, 0, 0, 1, 0, 0, 0); endfunction
  function automatic out_t o_ld(input logic [ADDR_W-1:0] a, input logic [31:0] w); return o(1, 0, a, w, 1, 1, 0, 0); endfunction
  function automatic out_t o_wr(input logic [ADDR_W-1:0] a, input logic [31:0] w); return o(0, 1, a, w, 1, 1, 0, 0); endfunction
  function automatic out_t o_dn(input logic [ADDR_W-1:0] a, input logic [31:0] w); return o(0, 0, a, w, 0, 0, 1, 0); endfunction
  function automatic out_t o_er(input logic [ADDR_W-1:0] a, input logic [31:0] w); return o(0, 0, a, w, 1, 0, 0, 1); endfunction

  task automatic add(input string nm, input logic r, input logic v, input logic [7:0] d, input out_t e);
    vec_t x;
    x.name = nm; x.rst = r; x.valid = v; x.data = d; x.exp = e;
    q.push_back(x);
  endtask

  function automatic out_t actual();
    return o(rx_ready, imem_we, imem_addr, imem_wdata, core_rst, busy, done, err);
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Full-size image bookkeeping
  int          n_wr;
  int          bad_wr;
  logic [ADDR_W-1:0] last_addr;
  logic [31:0] last_wdata;

  task automatic note_write();
    if (imem_we === 1'b1) begin
      n_wr++;
      last_addr  = imem_addr;
      last_wdata = imem_wdata;
      if (imem_wdata !== (32'h1000_0000 | 32'(imem_addr))) bad_wr++;
    end
  endtask

  task automatic send(input logic [7:0] b);
    int t = 0;
    @(negedge clk);
    rx_valid = 1'b1;
    rx_data  = b;
    while (rx_ready !== 1'b1 && t < 8) begin
      @(posedge clk); #1; note_write();
      @(negedge clk);
      t++;
    end
    if (rx_ready !== 1'b1) begin
      n_checks++;
      n_fail++;
      $display("FAIL send_timeout: rx_ready stuck at %b for byte %h", rx_ready, b);
    end
    @(posedge clk); #1; note_write();
    rx_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] s;
    logic [31:0] w;
    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00;

    // Single-word image
    add("t1_rst",   1, 0, 8'h00, o_rst());
    add("t1_nlo",   0, 1, 8'h01, o_ld(0, 0));
    add("t1_nhi",   0, 1, 8'h00, o_ld(0, 0));
    add("t1_b0",    0, 1, 8'h13, o_ld(0, 0));
    add("t1_b1",    0, 1, 8'h00, o_ld(0, 0));
    add("t1_b2",    0, 1, 8'h00, o_ld(0, 0));
    add("t1_wr",    0, 1, 8'h00, o_wr(0, 32'h0000_0013));
`ifdef PROG_LOADER_CHECKSUM_EN
    add("t1_chk",   0, 0, 8'h00, o_ld(0, 32'h0000_0013));
    add("t1_sum",   0, 1, 8'hED, o_dn(0, 32'h0000_0013));
`else
    add("t1_done",  0, 1, 8'h55, o_dn(0, 32'h0000_0013));
`endif
    add("t1_ign",   0, 1, 8'hAA, o_dn(0, 32'h0000_0013));

    // Two words, gapped valid, byte offered during WRITE must be held
    add("t2_rst",   1, 0, 8'h00, o_rst());
    add("t2_nlo",   0, 1, 8'h02, o_ld(0, 0));
    add("t2_gap0",  0, 0, 8'h00, o_ld(0, 0));
    add("t2_nhi",   0, 1, 8'h00, o_ld(0, 0));
    add("t2_gap1",  0, 0, 8'h00, o_ld(0, 0));
    add("t2_w0b0",  0, 1, 8'h93, o_ld(0, 0));
    add("t2_gap2",  0, 0, 8'h00, o_ld(0, 0));
    add("t2_w0b1",  0, 1, 8'h00, o_ld(0, 0));
    add("t2_gap3",  0, 0, 8'h00, o_ld(0, 0));
    add("t2_w0b2",  0, 1, 8'h50, o_ld(0, 0));
    add("t2_gap4",  0, 0, 8'h00, o_ld(0, 0));
    add("t2_wr0",   0, 1, 8'h00, o_wr(0, 32'h0050_0093));
    add("t2_held",  0, 1, 8'h13, o_ld(0, 32'h0050_0093));
    add("t2_w1b0",  0, 1, 8'h13, o_ld(0, 32'h0050_0093));
    add("t2_gap5",  0, 0, 8'h00, o_ld(0, 32'h0050_0093));
    add("t2_w1b1",  0, 1, 8'h01, o_ld(0, 32'h0050_0093));
    add("t2_gap6",  0, 0, 8'h00, o_ld(0, 32'h0050_0093));
    add("t2_w1b2",  0, 1, 8'hA0, o_ld(0, 32'h0050_0093));
    add("t2_gap7",  0, 0, 8'h00, o_ld(0, 32'h0050_0093));
    add("t2_wr1",   0, 1, 8'h00, o_wr(1, 32'h00A0_0113));
`ifdef PROG_LOADER_CHECKSUM_EN
    add("t2_chk",   0, 1, 8'h69, o_ld(1, 32'h00A0_0113));
    add("t2_sum",   0, 1, 8'h69, o_dn(1, 32'h00A0_0113));
`else
    add("t2_done",  0, 0, 8'h00, o_dn(1, 32'h00A0_0113));
`endif

    // Zero-length header
    add("t3_rst",   1, 0, 8'h00, o_rst());
    add("t3_nlo",   0, 1, 8'h00, o_ld(0, 0));
    add("t3_err",   0, 1, 8'h00, o_er(0, 0));
    add("t3_stick", 0, 1, 8'h13, o_er(0, 0));
    add("t3_clr",   1, 0, 8'h00, o_rst());

    // N = 1025 is one too many
    add("t4_nlo",   0, 1, 8'h01, o_ld(0, 0));
    add("t4_err",   0, 1, 8'h04, o_er(0, 0));
    add("t4_clr",   1, 0, 8'h00, o_rst());

    // Reset mid-word, then a fresh load
    add("t5_nlo",   0, 1, 8'h02, o_ld(0, 0));
    add("t5_nhi",   0, 1, 8'h00, o_ld(0, 0));
    add("t5_b0",    0, 1, 8'h11, o_ld(0, 0));
    add("t5_b1",    0, 1, 8'h22, o_ld(0, 0));
    add("t5_b2",    0, 1, 8'h33, o_ld(0, 0));
    add("t5_wr0",   0, 1, 8'h44, o_wr(0, 32'h4433_2211));
    add("t5_gap",   0, 0, 8'h00, o_ld(0, 32'h4433_2211));
    add("t5_p0",    0, 1, 8'h55, o_ld(0, 32'h4433_2211));
    add("t5_p1",    0, 1, 8'h66, o_ld(0, 32'h4433_2211));
    add("t5_rst",   1, 1, 8'h77, o_rst());
    add("t5_nlo2",  0, 1, 8'h01, o_ld(0, 0));
    add("t5_nhi2",  0, 1, 8'h00, o_ld(0, 0));
    add("t5_c0",    0, 1, 8'h13, o_ld(0, 0));
    add("t5_c1",    0, 1, 8'h00, o_ld(0, 0));
    add("t5_c2",    0, 1, 8'h00, o_ld(0, 0));
    add("t5_wr",    0, 1, 8'h00, o_wr(0, 32'h0000_0013));
`ifdef PROG_LOADER_CHECKSUM_EN
    add("t5_chk",   0, 0, 8'h00, o_ld(0, 32'h0000_0013));
    add("t5_sum",   0, 1, 8'hED, o_dn(0, 32'h0000_0013));

    // Bad checksum
    add("t6_rst",   1, 0, 8'h00, o_rst());
    add("t6_nlo",   0, 1, 8'h01, o_ld(0, 0));
    add("t6_nhi",   0, 1, 8'h00, o_ld(0, 0));
    add("t6_b0",    0, 1, 8'h13, o_ld(0, 0));
    add("t6_b1",    0, 1, 8'h00, o_ld(0, 0));
    add("t6_b2",    0, 1, 8'h00, o_ld(0, 0));
    add("t6_wr",    0, 1, 8'h00, o_wr(0, 32'h0000_0013));
    add("t6_chk",   0, 0, 8'h00, o_ld(0, 32'h0000_0013));
    add("t6_bad",   0, 1, 8'hEE, o_er(0, 32'h0000_0013));
    add("t6_stick", 0, 1, 8'h00, o_er(0, 32'h0000_0013));
`else
    add("t5_done",  0, 0, 8'h00, o_dn(0, 32'h0000_0013));
`endif

    foreach (q[i]) begin
      @(negedge clk);
      rst      = q[i].rst;
      rx_valid = q[i].valid;
      rx_data  = q[i].data;
      @(posedge clk); #1;
      check(q[i].name, 64'(actual()), 64'(q[i].exp));
    end

    // Largest image: 1024 words, last write lands at addr 1023
    @(negedge clk);
    rst = 1'b1; rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    n_wr = 0; bad_wr = 0; last_addr = '0; last_wdata = '0; s = 8'h00;
    send(8'h00);
    send(8'h04);
    for (int i = 0; i < 1024; i++) begin
      w = 32'h1000_0000 | 32'(i);
      for (int k = 0; k < 4; k++) begin
        s = s + w[8*k +: 8];
        send(w[8*k +: 8]);
      end
    end
`ifdef PROG_LOADER_CHECKSUM_EN
    send(8'(8'h00 - s));
`else
    @(posedge clk); #1;
`endif
    check("big_count", 64'(n_wr), 64'd1024);
    check("big_last_addr", 64'(last_addr), 64'd1023);
    check("big_last_data", 64'(last_wdata), 64'h1000_03FF);
    check("big_data_ok", 64'(bad_wr), 64'd0);
    check("big_done", 64'({done, core_rst, err}), 64'b100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
